fetch_unit: RTL

- Instruction fetch stage that sits directly upstream of the controller.
- Owns the PC register and issues requests to instruction memory over a req/ready + rvalid handshake.
- Holds the fetched instruction stable until the core retires it.
- Drives op/funct3/funct7b5 to the controller and consumes PCSrc/PCTarget back to select the next PC.

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the PC, fetches over a
//               req/ready + rvalid handshake and holds Instr until retire.
//               Optional macro FETCH_MISALIGN_TRAP_EN adds a sticky
//               misaligned-target trap and a halt state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    input  logic        retire,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign
`endif
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] w_pc_next;
    logic        w_capture;
    logic        w_load_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        w_trap;
    logic        r_misalign;
`else
    // Target low bits are architecturally dropped when no trap is built.
    logic        w_unused_tgt_lsb;
    assign w_unused_tgt_lsb = ^PCTarget[1:0];
`endif

    assign PC        = r_pc;
    assign PCPlus4   = r_pc + 32'd4;
    assign Instr     = r_instr;
    assign op        = r_instr[6:0];
    assign funct3    = r_instr[14:12];
    assign funct7b5  = r_instr[30];
    assign imem_addr = r_pc;
    // Gated by reset so no request escapes while the memory is being reset.
    assign imem_req    = reset & (r_state == S_REQ);
    assign instr_valid = (r_state == S_VALID);

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_load_pc    = 1'b0;
        w_pc_next    = PCSrc ? {PCTarget[31:2], 2'b00} : PCPlus4;
`ifdef FETCH_MISALIGN_TRAP_EN
        w_trap       = 1'b0;
`endif
        case (r_state)
            S_REQ: begin
                if (imem_ready) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_capture    = 1'b1;
                    w_next_state = S_VALID;
                end
            end
            S_VALID: begin
                if (retire) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (PCSrc && (PCTarget[1:0] != 2'b00)) begin
                        w_trap       = 1'b1;
                        w_next_state = S_HALT;
                    end else begin
                        w_load_pc    = 1'b1;
                        w_next_state = S_REQ;
                    end
`else
                    w_load_pc    = 1'b1;
                    w_next_state = S_REQ;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_HALT: begin
                w_next_state = S_HALT;
            end
`endif
            default: begin
                w_next_state = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
            if (w_load_pc) begin
                r_pc <= w_pc_next;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misalign <= 1'b0;
        end else if (w_trap) begin
            r_misalign <= 1'b1;
        end
    end

    assign fetch_misalign = r_misalign;
`endif

endmodule

`default_nettype wire
